// File: rtl/mii_udp_rx.sv
// MII nibble receiver: preamble/SFD detection, Ethernet/IPv4/UDP header filtering,
// UDP payload streaming and Ethernet FCS residue check.
module mii_udp_rx #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
  parameter logic [15:0] LOCAL_PORT = 16'd6000
) (
  input  logic        mii_rx_clk,
  input  logic        rst_n,
  input  logic        mii_rx_dv,
  input  logic        mii_rx_er,
  input  logic [3:0]  mii_rx_da,
  output logic        pl_wr_en,
  output logic [7:0]  pl_wr_da,
  output logic        pl_sop,
  output logic        pl_eop,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic [15:0] pl_len,
  output logic        frame_done,
  output logic        frame_ok
);

  typedef enum logic [3:0] {
    WAIT_IDLE, IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER, DROP
  } state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  lo_q, lo_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;
  logic        uc_q, uc_d;
  logic        bc_q, bc_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] pl_cnt_q, pl_cnt_d;
  logic [15:0] pl_len_q, pl_len_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_da_q, wr_da_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;

  logic [7:0]  rx_byte;
  logic [7:0]  mac_byte;
  logic [7:0]  ip_byte;
  logic [15:0] udp_len;
  logic        in_frame;
  logic        byte_done;

  // Reflected CRC-32, one nibble per call (LSB first, matching MII nibble order).
  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c ^ {28'd0, n};
    for (int i = 0; i < 4; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
    end
    return r;
  endfunction

  assign rx_byte   = {mii_rx_da, lo_q};
  assign udp_len   = {len_hi_q, rx_byte};
  assign in_frame  = (state_q == ETH_HDR) || (state_q == IP_HDR) || (state_q == UDP_HDR) ||
                     (state_q == PAYLOAD) || (state_q == TRAILER) || (state_q == DROP);
  assign byte_done = in_frame && mii_rx_dv && phase_q;

  // Expected header bytes selected by the byte counter position.
  always_comb begin
    case (cnt_q[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      default: mac_byte = LOCAL_MAC[7:0];
    endcase
    case (cnt_q[1:0])
      2'd2:    ip_byte = LOCAL_IP[31:24];
      2'd3:    ip_byte = LOCAL_IP[23:16];
      2'd0:    ip_byte = LOCAL_IP[15:8];
      default: ip_byte = LOCAL_IP[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    err_d      = err_q;
    uc_d       = uc_q;
    bc_d       = bc_q;
    len_hi_d   = len_hi_q;
    pl_cnt_d   = pl_cnt_q;
    pl_len_d   = pl_len_q;
    src_ip_d   = src_ip_q;
    src_port_d = src_port_q;
    wr_en_d    = 1'b0;
    wr_da_d    = wr_da_q;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    done_d     = 1'b0;
    ok_d       = 1'b0;

    if (in_frame && mii_rx_dv) begin
      crc_d   = crc_nibble(crc_q, mii_rx_da);
      err_d   = err_q | mii_rx_er;
      phase_d = ~phase_q;
      if (!phase_q) lo_d = mii_rx_da;
      else          cnt_d = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    end else if (in_frame) begin
      // Only a frame that reached TRAILER has matched headers and a complete payload.
      state_d = IDLE;
      done_d  = 1'b1;
      ok_d    = (state_q == TRAILER) && (crc_q == CRC_RESIDUE) && !err_q && !phase_q;
    end

    case (state_q)
      WAIT_IDLE: if (!mii_rx_dv) state_d = IDLE;
      IDLE: begin
        if (mii_rx_dv) state_d = (mii_rx_da == 4'h5) ? PREAMBLE : WAIT_IDLE;
      end
      PREAMBLE: begin
        if (!mii_rx_dv || (mii_rx_da != 4'h5 && mii_rx_da != 4'hD)) begin
          state_d = WAIT_IDLE;
        end else if (mii_rx_da == 4'hD) begin
          state_d = ETH_HDR;
          phase_d = 1'b0;
          cnt_d   = 11'd0;
          crc_d   = 32'hFFFFFFFF;
          err_d   = 1'b0;
          uc_d    = 1'b1;
          bc_d    = 1'b1;
        end
      end
      ETH_HDR: if (byte_done) begin
        if (cnt_q < 11'd6) begin
          uc_d = uc_q && (rx_byte == mac_byte);
          bc_d = bc_q && (rx_byte == 8'hFF);
          if (!uc_d && !bc_d) state_d = DROP;
        end else if (cnt_q == 11'd12) begin
          if (rx_byte != 8'h08) state_d = DROP;
        end else if (cnt_q == 11'd13) begin
          state_d = (rx_byte == 8'h00) ? IP_HDR : DROP;
        end
      end
      IP_HDR: if (byte_done) begin
        case (cnt_q)
          11'd14: if (rx_byte != 8'h45) state_d = DROP;
          11'd23: if (rx_byte != 8'd17) state_d = DROP;
          11'd26, 11'd27, 11'd28, 11'd29: src_ip_d = {src_ip_q[23:0], rx_byte};
          11'd30, 11'd31, 11'd32: if (rx_byte != ip_byte) state_d = DROP;
          11'd33: state_d = (rx_byte == ip_byte) ? UDP_HDR : DROP;
          default: ;
        endcase
      end
      UDP_HDR: if (byte_done) begin
        case (cnt_q)
          11'd34, 11'd35: src_port_d = {src_port_q[7:0], rx_byte};
          11'd36: if (rx_byte != LOCAL_PORT[15:8]) state_d = DROP;
          11'd37: if (rx_byte != LOCAL_PORT[7:0]) state_d = DROP;
          11'd38: len_hi_d = rx_byte;
          11'd39: begin
            if (udp_len < 16'd8) state_d = DROP;
            else                 pl_len_d = udp_len - 16'd8;
          end
          11'd41: begin
            pl_cnt_d = 16'd0;
            state_d  = (pl_len_q == 16'd0) ? TRAILER : PAYLOAD;
          end
          default: ;
        endcase
      end
      PAYLOAD: if (byte_done) begin
        wr_en_d  = 1'b1;
        wr_da_d  = rx_byte;
        sop_d    = (pl_cnt_q == 16'd0);
        eop_d    = (pl_cnt_q == pl_len_q - 16'd1);
        pl_cnt_d = pl_cnt_q + 16'd1;
        if (eop_d) state_d = TRAILER;
      end
      default: ;
    endcase
  end

  always_ff @(posedge mii_rx_clk) begin
    if (!rst_n) begin
      state_q    <= WAIT_IDLE;
      phase_q    <= 1'b0;
      lo_q       <= 4'd0;
      cnt_q      <= 11'd0;
      crc_q      <= 32'd0;
      err_q      <= 1'b0;
      uc_q       <= 1'b0;
      bc_q       <= 1'b0;
      len_hi_q   <= 8'd0;
      pl_cnt_q   <= 16'd0;
      pl_len_q   <= 16'd0;
      src_ip_q   <= 32'd0;
      src_port_q <= 16'd0;
      wr_en_q    <= 1'b0;
      wr_da_q    <= 8'd0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      err_q      <= err_d;
      uc_q       <= uc_d;
      bc_q       <= bc_d;
      len_hi_q   <= len_hi_d;
      pl_cnt_q   <= pl_cnt_d;
      pl_len_q   <= pl_len_d;
      src_ip_q   <= src_ip_d;
      src_port_q <= src_port_d;
      wr_en_q    <= wr_en_d;
      wr_da_q    <= wr_da_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
    end
  end

  assign pl_wr_en   = wr_en_q;
  assign pl_wr_da   = wr_da_q;
  assign pl_sop     = sop_q;
  assign pl_eop     = eop_q;
  assign src_ip     = src_ip_q;
  assign src_port   = src_port_q;
  assign pl_len     = pl_len_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;

endmodule

// File: tb/tb_mii_udp_rx.sv
// Bench for mii_udp_rx: builds Ethernet/IPv4/UDP frames, drives them as MII nibbles and
// compares payload strobes and frame status against a frame-level reference model.
module tb_mii_udp_rx;
  localparam logic [47:0] LMAC  = 48'h000A3501FEC0;
  localparam logic [31:0] LIP   = 32'hC0A80002;
  localparam logic [15:0] LPORT = 16'd6000;

  logic        mii_rx_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mii_rx_dv = 1'b0;
  logic        mii_rx_er = 1'b0;
  logic [3:0]  mii_rx_da = 4'd0;
  logic        pl_wr_en, pl_sop, pl_eop, frame_done, frame_ok;
  logic [7:0]  pl_wr_da;
  logic [31:0] src_ip;
  logic [15:0] src_port, pl_len;

  always #20 mii_rx_clk = ~mii_rx_clk;

  mii_udp_rx #(.LOCAL_MAC(LMAC), .LOCAL_IP(LIP), .LOCAL_PORT(LPORT)) dut (
    .mii_rx_clk(mii_rx_clk), .rst_n(rst_n), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .mii_rx_da(mii_rx_da), .pl_wr_en(pl_wr_en), .pl_wr_da(pl_wr_da), .pl_sop(pl_sop),
    .pl_eop(pl_eop), .src_ip(src_ip), .src_port(src_port), .pl_len(pl_len),
    .frame_done(frame_done), .frame_ok(frame_ok)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  fr[$];
  logic [7:0]  pay[$];
  logic [7:0]  exp_pay[$];
  logic [31:0] cur_sip;
  logic [15:0] cur_sport;

  // Output monitor: every strobe and frame_done is logged with its cycle number.
  int          cyc = 0;
  logic [7:0]  m_da[$];
  bit          m_sop[$];
  bit          m_eop[$];
  int          m_cyc[$];
  logic [15:0] m_len[$];
  int          m_done = 0;
  bit          m_ok = 1'b0;

  always @(posedge mii_rx_clk) cyc <= cyc + 1;

  always @(negedge mii_rx_clk) begin
    if (pl_wr_en) begin
      m_da.push_back(pl_wr_da);
      m_sop.push_back(pl_sop);
      m_eop.push_back(pl_eop);
      m_cyc.push_back(cyc);
      m_len.push_back(pl_len);
    end
    if (frame_done) begin
      m_done = m_done + 1;
      m_ok   = frame_ok;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ethernet FCS over fr[0..n-1], computed bytewise in the usual transmit form.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fr[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Frame bytes after the SFD, payload taken from pay[]; ulen < 0 means the true UDP length.
  task automatic build(input logic [47:0] mac, input logic [31:0] dip, input logic [15:0] dport,
                       input int pad, input int ulen);
    logic [31:0] c;
    int ul, tl;
    cur_sip   = $urandom;
    cur_sport = 16'($urandom);
    ul = (ulen < 0) ? pay.size() + 8 : ulen;
    tl = pay.size() + 28;
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(mac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
    fr.push_back(8'h08); fr.push_back(8'h00);
    fr.push_back(8'h45); fr.push_back(8'h00); fr.push_back(8'(tl >> 8)); fr.push_back(8'(tl));
    fr.push_back(8'($urandom)); fr.push_back(8'($urandom)); fr.push_back(8'h40); fr.push_back(8'h00);
    fr.push_back(8'h40); fr.push_back(8'd17); fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) fr.push_back(cur_sip[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) fr.push_back(dip[31-8*i -: 8]);
    fr.push_back(cur_sport[15:8]); fr.push_back(cur_sport[7:0]);
    fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
    fr.push_back(8'(ul >> 8)); fr.push_back(8'(ul));
    fr.push_back(8'h00); fr.push_back(8'h00);
    foreach (pay[i]) fr.push_back(pay[i]);
    for (int i = 0; i < pad; i++) fr.push_back(8'h00);
    c = fcs_of(fr.size());
    fr.push_back(c[7:0]); fr.push_back(c[15:8]); fr.push_back(c[23:16]); fr.push_back(c[31:24]);
  endtask

  // Reference model: acceptance decided by parsing the first nsend wire bytes.
  task automatic model(input int nsend, input bit er, input bit odd,
                       output bit ok, output int cnt, output int plen);
    bit          hdr;
    logic [47:0] dmac;
    logic [15:0] ul;
    logic [31:0] wire_fcs;
    dmac = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
    ul   = {fr[38], fr[39]};
    hdr  = (dmac == LMAC || dmac == 48'hFFFFFFFFFFFF) && ({fr[12], fr[13]} == 16'h0800) &&
           (fr[14] == 8'h45) && (fr[23] == 8'd17) &&
           ({fr[30], fr[31], fr[32], fr[33]} == LIP) && ({fr[36], fr[37]} == LPORT) && (ul >= 16'd8);
    plen = hdr ? int'(ul) - 8 : 0;
    cnt  = 0;
    if (hdr && nsend >= 42) cnt = (nsend - 42 < plen) ? nsend - 42 : plen;
    exp_pay.delete();
    for (int i = 0; i < cnt; i++) exp_pay.push_back(fr[42+i]);
    wire_fcs = {fr[nsend-1], fr[nsend-2], fr[nsend-3], fr[nsend-4]};
    ok = hdr && (nsend >= 42 + plen) && (fcs_of(nsend - 4) == wire_fcs) && !er && !odd;
  endtask

  task automatic drive(input bit dv, input logic [3:0] d, input bit er, input bit rn);
    @(negedge mii_rx_clk);
    mii_rx_dv = dv;
    mii_rx_da = d;
    mii_rx_er = er;
    rst_n     = rn;
  endtask

  task automatic send(input int nsend, input int er_nib, input int rst_nib, input bit odd);
    logic [7:0] b;
    bit         in_rst;
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0, 1'b1);
    drive(1'b1, 4'hD, 1'b0, 1'b1);
    for (int k = 0; k < 2 * nsend; k++) begin
      b = fr[k/2];
      in_rst = (rst_nib >= 0) && (k == rst_nib || k == rst_nib + 1);
      drive(1'b1, (k % 2 == 1) ? b[7:4] : b[3:0], k == er_nib, !in_rst);
      if (rst_nib >= 0 && k == rst_nib + 1) begin
        check("rst strobes", 32'({pl_wr_en, pl_wr_da, pl_sop, pl_eop, frame_done, frame_ok}), 32'd0);
        check("rst src_ip", src_ip, 32'd0);
        check("rst src_port/pl_len", {src_port, pl_len}, 32'd0);
      end
    end
    if (odd) drive(1'b1, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic run(input string tag, input int nsend, input int er_nib, input int rst_nib, input bit odd);
    bit ok;
    int cnt, plen, d0, s0, got, exp_done;
    model(nsend, er_nib >= 0, odd, ok, cnt, plen);
    exp_done = 1;
    if (rst_nib >= 0) begin
      exp_done = 0;
      cnt = 0;
      ok = 1'b0;
    end
    d0 = m_done;
    s0 = m_da.size();
    send(nsend, er_nib, rst_nib, odd);
    got = m_da.size() - s0;
    check({tag, " frame_done count"}, 32'(m_done - d0), 32'(exp_done));
    if (exp_done == 1) check({tag, " frame_ok"}, 32'(m_ok), 32'(ok));
    check({tag, " strobe count"}, 32'(got), 32'(cnt));
    for (int i = 0; i < cnt && i < got; i++) begin
      check({tag, " data"}, 32'(m_da[s0+i]), 32'(exp_pay[i]));
      check({tag, " sop"}, 32'(m_sop[s0+i]), 32'(i == 0));
      check({tag, " eop"}, 32'(m_eop[s0+i]), 32'(i == cnt - 1 && cnt == plen));
      if (i > 0) check({tag, " strobe spacing"}, 32'(m_cyc[s0+i] - m_cyc[s0+i-1]), 32'd2);
    end
    if (cnt > 0 && got > 0) check({tag, " pl_len"}, 32'(m_len[s0]), 32'(plen));
    if (ok && exp_done == 1) begin
      check({tag, " src_ip"}, src_ip, cur_sip);
      check({tag, " src_port"}, 32'(src_port), 32'(cur_sport));
    end
    $display("frame %s: bytes=%0d strobes=%0d/%0d done=%0d ok=%0d/%0d", tag, nsend, got, cnt,
             m_done - d0, m_ok, ok);
  endtask

  task automatic random_payload(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    string hello;
    int    choice, idx;
    hello = "Hello, FPGA World!";

    for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 1'b0, 1'b0);
    check("reset pl_wr_en", 32'(pl_wr_en), 32'd0);
    check("reset pl_wr_da", 32'(pl_wr_da), 32'd0);
    check("reset sop/eop", 32'({pl_sop, pl_eop}), 32'd0);
    check("reset frame_done/ok", 32'({frame_done, frame_ok}), 32'd0);
    check("reset src_ip", src_ip, 32'd0);
    check("reset src_port", 32'(src_port), 32'd0);
    check("reset pl_len", 32'(pl_len), 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 1'b0, 1'b1);

    pay.delete();
    for (int i = 0; i < hello.len(); i++) pay.push_back(hello[i]);
    build(LMAC, LIP, LPORT, 1, -1);
    run("hello", fr.size(), -1, -1, 1'b0);

    build(LMAC, LIP, 16'd6001, 1, -1);
    run("port6001", fr.size(), -1, -1, 1'b0);

    build(48'hFFFFFFFFFFFF, LIP, LPORT, 1, -1);
    fr[45] = fr[45] ^ 8'h40;
    run("bcast_corrupt", fr.size(), -1, -1, 1'b0);

    build(LMAC, LIP, LPORT, 1, -1);
    run("truncated", 47, -1, -1, 1'b0);

    random_payload(18);
    build(LMAC, LIP, LPORT, 0, -1);
    run("after_trunc", fr.size(), -1, -1, 1'b0);

    build(LMAC, LIP, LPORT, 1, -1);
    run("rx_er_udp", fr.size(), 72, -1, 1'b0);

    build(LMAC, LIP, LPORT, 1, -1);
    run("reset_ip", fr.size(), -1, 40, 1'b0);

    build(LMAC, LIP, LPORT, 2, -1);
    run("after_reset", fr.size(), -1, -1, 1'b0);

    random_payload(0);
    build(LMAC, LIP, LPORT, 18, -1);
    run("plen0", fr.size(), -1, -1, 1'b0);

    random_payload(1);
    build(48'hFFFFFFFFFFFF, LIP, LPORT, 17, -1);
    run("plen1", fr.size(), -1, -1, 1'b0);

    random_payload(6);
    build(LMAC, LIP, LPORT, 0, -1);
    run("odd_nibble", fr.size(), -1, -1, 1'b1);

    random_payload(10);
    build(LMAC, LIP, LPORT, 0, 5);
    run("udp_len_short", fr.size(), -1, -1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      choice = $urandom_range(0, 6);
      random_payload($urandom_range(0, 30));
      case (choice)
        1:       build(LMAC ^ 48'h1, LIP, LPORT, $urandom_range(0, 3), -1);
        2:       build(48'hFFFFFFFFFFFF, LIP, LPORT, $urandom_range(0, 3), -1);
        3:       build(LMAC, LIP + 32'd1, LPORT, $urandom_range(0, 3), -1);
        4:       build(LMAC, LIP, LPORT + 16'd1, $urandom_range(0, 3), -1);
        6:       build(LMAC, LIP, LPORT, $urandom_range(0, 3), $urandom_range(0, 7));
        default: build(LMAC, LIP, LPORT, $urandom_range(0, 3), -1);
      endcase
      if (choice == 5) begin
        idx = $urandom_range(0, fr.size() - 5);
        fr[idx] = fr[idx] ^ 8'(1 << $urandom_range(0, 7));
      end
      run($sformatf("rand%0d_c%0d", r, choice), fr.size(), -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
